// File: rtl/uart_pkg.sv
// Shared constants, FSM state types and host opcodes for the UART command receiver.
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEF = 434;
    localparam logic [7:0]  SYNC_BYTE_DEF    = 8'hA5;

    localparam logic [7:0] OP_FFT_ENABLE = 8'h01;
    localparam logic [7:0] OP_ACC_RANGE  = 8'h02;
    localparam logic [7:0] OP_DECIMATE   = 8'h03;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } byte_state_e;

    typedef enum logic [2:0] {
        P_SYNC,
        P_OP,
        P_DHI,
        P_DLO,
        P_CHK
    } pkt_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchroniser, mid-bit sampling FSM, framing check.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_byte_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    byte_state_e state_q, state_d;
    logic          sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_d     = bit_q;
        shift_d   = shift_q;
        rx_byte_d = rx_byte_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!sync2_q) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync2_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (sync2_q) begin
                        valid_d   = 1'b1;
                        rx_byte_d = shift_q;
                        state_d   = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_d = '0;
                if (sync2_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            rx_byte_q <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            sync1_q   <= rx;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            rx_byte_q <= rx_byte_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    assign rx_byte       = rx_byte_q;
    assign rx_byte_valid = valid_q;
    assign frame_err     = ferr_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: rtl/uart_cmd_rx.sv
// 5-byte command packet receiver (sync, opcode, data hi, data lo, xor checksum)
// built on uart_rx_byte, with an inter-byte silence timeout.
module uart_cmd_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEF,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic        sys_clock,
    input  logic        reset,
    input  logic        UART_RX,
    output logic        cmd_valid,
    output logic [7:0]  cmd_opcode,
    output logic [15:0] cmd_data,
    output logic        rx_byte_valid,
    output logic [7:0]  rx_byte,
    output logic        frame_err,
    output logic        chk_err
);

    localparam int unsigned TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned TW       = $clog2(TO_LIMIT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TO_LIMIT - 1);

    logic byte_busy;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx_byte (
        .clk          (sys_clock),
        .rst          (reset),
        .rx           (UART_RX),
        .rx_byte      (rx_byte),
        .rx_byte_valid(rx_byte_valid),
        .frame_err    (frame_err),
        .busy         (byte_busy)
    );

    pkt_state_e pkt_q, pkt_d;
    logic [7:0]    op_sh_q, op_sh_d;
    logic [7:0]    hi_sh_q, hi_sh_d;
    logic [7:0]    lo_sh_q, lo_sh_d;
    logic [7:0]    opcode_q, opcode_d;
    logic [15:0]   data_q, data_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic          chk_err_q, chk_err_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          timeout;

    always_comb begin
        pkt_d       = pkt_q;
        op_sh_d     = op_sh_q;
        hi_sh_d     = hi_sh_q;
        lo_sh_d     = lo_sh_q;
        opcode_d    = opcode_q;
        data_d      = data_q;
        cmd_valid_d = 1'b0;
        chk_err_d   = 1'b0;
        to_cnt_d    = '0;
        timeout     = 1'b0;

        // Silence is only counted between bytes of a partially received packet.
        if (pkt_q != P_SYNC && !byte_busy) begin
            if (to_cnt_q == TO_LAST) timeout = 1'b1;
            else                     to_cnt_d = to_cnt_q + 1'b1;
        end

        if (rx_byte_valid) begin
            case (pkt_q)
                P_SYNC: if (rx_byte == SYNC_BYTE) pkt_d = P_OP;
                P_OP: begin
                    op_sh_d = rx_byte;
                    pkt_d   = P_DHI;
                end
                P_DHI: begin
                    hi_sh_d = rx_byte;
                    pkt_d   = P_DLO;
                end
                P_DLO: begin
                    lo_sh_d = rx_byte;
                    pkt_d   = P_CHK;
                end
                P_CHK: begin
                    if (rx_byte == (op_sh_q ^ hi_sh_q ^ lo_sh_q)) begin
                        cmd_valid_d = 1'b1;
                        opcode_d    = op_sh_q;
                        data_d      = {hi_sh_q, lo_sh_q};
                    end else begin
                        chk_err_d = 1'b1;
                    end
                    pkt_d = P_SYNC;
                end
                default: pkt_d = P_SYNC;
            endcase
        end

        if (frame_err || timeout) pkt_d = P_SYNC;
    end

    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            pkt_q       <= P_SYNC;
            op_sh_q     <= '0;
            hi_sh_q     <= '0;
            lo_sh_q     <= '0;
            opcode_q    <= '0;
            data_q      <= '0;
            cmd_valid_q <= 1'b0;
            chk_err_q   <= 1'b0;
            to_cnt_q    <= '0;
        end else begin
            pkt_q       <= pkt_d;
            op_sh_q     <= op_sh_d;
            hi_sh_q     <= hi_sh_d;
            lo_sh_q     <= lo_sh_d;
            opcode_q    <= opcode_d;
            data_q      <= data_d;
            cmd_valid_q <= cmd_valid_d;
            chk_err_q   <= chk_err_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    assign cmd_valid  = cmd_valid_q;
    assign cmd_opcode = opcode_q;
    assign cmd_data   = data_q;
    assign chk_err    = chk_err_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Scoreboard bench for uart_cmd_rx: stimulus queues expected bytes and commands, a monitor checks them.
module tb_uart_cmd_rx;

    localparam int unsigned CPB = 8;
    localparam int unsigned TOB = 4;

    logic        sys_clock = 1'b0;
    logic        reset     = 1'b1;
    logic        UART_RX   = 1'b1;
    logic        cmd_valid;
    logic [7:0]  cmd_opcode;
    logic [15:0] cmd_data;
    logic        rx_byte_valid;
    logic [7:0]  rx_byte;
    logic        frame_err;
    logic        chk_err;

    uart_cmd_rx #(
        .CLKS_PER_BIT(CPB),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_BITS(TOB)
    ) dut (
        .sys_clock    (sys_clock),
        .reset        (reset),
        .UART_RX      (UART_RX),
        .cmd_valid    (cmd_valid),
        .cmd_opcode   (cmd_opcode),
        .cmd_data     (cmd_data),
        .rx_byte_valid(rx_byte_valid),
        .rx_byte      (rx_byte),
        .frame_err    (frame_err),
        .chk_err      (chk_err)
    );

    always #5 sys_clock = ~sys_clock;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0]  exp_bytes[$];
    logic [23:0] exp_cmds[$];
    int exp_chk    = 0;
    int exp_ferr   = 0;
    int seen_chk   = 0;
    int seen_ferr  = 0;
    logic prev_rbv = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        @(negedge sys_clock);
        UART_RX = v;
        repeat (CPB - 1) @(negedge sys_clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input logic expect_ok);
        if (expect_ok) exp_bytes.push_back(b);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
        if (stop) begin
            @(negedge sys_clock);
            UART_RX = 1'b1;
        end
    endtask

    task automatic send_pkt(input logic [7:0] op, input logic [15:0] d, input logic [7:0] ck);
        if (ck == (op ^ d[15:8] ^ d[7:0])) exp_cmds.push_back({op, d});
        else exp_chk++;
        send_byte(8'hA5, 1'b1, 1'b1);
        send_byte(op, 1'b1, 1'b1);
        send_byte(d[15:8], 1'b1, 1'b1);
        send_byte(d[7:0], 1'b1, 1'b1);
        send_byte(ck, 1'b1, 1'b1);
        repeat (6) @(negedge sys_clock);
    endtask

    // Monitor: pops expectations whenever the DUT presents an output pulse.
    always @(negedge sys_clock) begin
        if (!reset) begin
            if (rx_byte_valid) begin
                if (exp_bytes.size() == 0) check("unexpected_rx_byte", {24'h0, rx_byte}, 32'hFFFF_FFFF);
                else check("rx_byte", {24'h0, rx_byte}, {24'h0, exp_bytes.pop_front()});
            end
            if (cmd_valid) begin
                check("cmd_latency", {31'h0, prev_rbv}, 32'h1);
                check("cmd_vs_chk_err", {31'h0, chk_err}, 32'h0);
                if (exp_cmds.size() == 0) check("unexpected_cmd", {8'h0, cmd_opcode, cmd_data}, 32'hFFFF_FFFF);
                else check("cmd", {8'h0, cmd_opcode, cmd_data}, {8'h0, exp_cmds.pop_front()});
            end
            if (chk_err) begin
                check("chk_err_latency", {31'h0, prev_rbv}, 32'h1);
                seen_chk++;
            end
            if (frame_err) seen_ferr++;
            prev_rbv <= rx_byte_valid;
        end else begin
            prev_rbv <= 1'b0;
        end
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1;
        check("reset_cmd_valid", {31'h0, cmd_valid}, 32'h0);
        check("reset_outputs", {cmd_opcode, cmd_data, rx_byte}, 32'h0);
        check("reset_pulses", {29'h0, rx_byte_valid, frame_err, chk_err}, 32'h0);
        repeat (3) @(negedge sys_clock);
        reset = 1'b0;
        repeat (5) @(negedge sys_clock);

        send_pkt(8'h01, 16'h1234, 8'h27);

        send_pkt(8'h01, 16'h1234, 8'h00);
        check("hold_after_chk_err", {8'h0, cmd_opcode, cmd_data}, 32'h0001_1234);
        send_pkt(8'h02, 16'h0005, 8'h07);

        // Short low glitch must not start a byte.
        @(negedge sys_clock);
        UART_RX = 1'b0;
        repeat (3) @(negedge sys_clock);
        UART_RX = 1'b1;
        repeat (20) @(negedge sys_clock);
        send_pkt(8'h03, 16'h0102, 8'h00);
        send_pkt(8'h01, 16'hBEEF, 8'h01 ^ 8'hBE ^ 8'hEF);

        // Framing error mid-packet, line held low, then a clean packet.
        send_byte(8'hA5, 1'b1, 1'b1);
        send_byte(8'h01, 1'b1, 1'b1);
        exp_ferr++;
        send_byte(8'h55, 1'b0, 1'b0);
        repeat (40) @(negedge sys_clock);
        UART_RX = 1'b1;
        repeat (10) @(negedge sys_clock);
        check("frame_err_count", seen_ferr, exp_ferr);
        send_pkt(8'h03, 16'hABCD, 8'h65);

        // Noise bytes dropped, partial packet timed out.
        send_byte(8'h00, 1'b1, 1'b1);
        send_byte(8'hFF, 1'b1, 1'b1);
        send_byte(8'hA5, 1'b1, 1'b1);
        send_byte(8'h01, 1'b1, 1'b1);
        repeat (40) @(negedge sys_clock);
        send_pkt(8'h02, 16'h0005, 8'h07);

        // Reset in the middle of the third byte's data bits.
        send_byte(8'hA5, 1'b1, 1'b1);
        send_byte(8'h12, 1'b1, 1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        @(negedge sys_clock);
        #2 reset = 1'b1;
        #1;
        check("midreset_outputs", {cmd_opcode, cmd_data, rx_byte}, 32'h0);
        check("midreset_pulses", {28'h0, cmd_valid, rx_byte_valid, frame_err, chk_err}, 32'h0);
        UART_RX = 1'b1;
        repeat (4) @(negedge sys_clock);
        reset = 1'b0;
        repeat (20) @(negedge sys_clock);
        send_pkt(8'h01, 16'h00FF, 8'hFE);

        repeat (20) @(negedge sys_clock);
        check("bytes_left", exp_bytes.size(), 0);
        check("cmds_left", exp_cmds.size(), 0);
        check("chk_err_count", seen_chk, exp_chk);
        check("frame_err_total", seen_ferr, exp_ferr);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
